// File: rtl/algo_1r1w_refresh_sched_if.sv
// Request/grant/refresh bundle between the T1 request logic and the refresh scheduler.
// Optional blk_cnt statistics signal appears when REFSCHED_STATS_EN is defined.
interface algo_1r1w_refresh_sched_if #(
    parameter int BITRBNK = 1,
    parameter int BITRROW = 8
);
    logic               ref_en;
    logic               rd_req;
    logic [BITRBNK-1:0] rd_rbnk;
    logic               wr_req;
    logic [BITRBNK-1:0] wr_rbnk;
    logic               rd_gnt;
    logic               wr_gnt;
    logic               ref_vld;
    logic [BITRBNK-1:0] ref_rbnk;
    logic [BITRROW-1:0] ref_rrow;
    logic               ref_wrap;
    logic               ref_ovf;
`ifdef REFSCHED_STATS_EN
    logic [15:0]        blk_cnt;
`endif

    modport master (
        output ref_en, rd_req, rd_rbnk, wr_req, wr_rbnk,
        input  rd_gnt, wr_gnt, ref_vld, ref_rbnk, ref_rrow, ref_wrap, ref_ovf
`ifdef REFSCHED_STATS_EN
        , input blk_cnt
`endif
    );

    modport slave (
        input  ref_en, rd_req, rd_rbnk, wr_req, wr_rbnk,
        output rd_gnt, wr_gnt, ref_vld, ref_rbnk, ref_rrow, ref_wrap, ref_ovf
`ifdef REFSCHED_STATS_EN
        , output blk_cnt
`endif
    );
endinterface

// File: rtl/algo_1r1w_refresh_sched.sv
// Refresh slot generator and refresh/access arbiter for the refreshable T1 banks.
// Define REFSCHED_STATS_EN to add the saturating blk_cnt count of grants suppressed by forced refresh.
module algo_1r1w_refresh_sched #(
    parameter int NUMRBNK  = 2,
    parameter int BITRBNK  = 1,
    parameter int NUMRROW  = 256,
    parameter int BITRROW  = 8,
    parameter int REFFREQ  = 6,
    parameter int REFFRHF  = 0,
    parameter int MAXDEFER = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    algo_1r1w_refresh_sched_if.slave     bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FORCE = 2'd2} state_t;

    localparam logic [BITRBNK-1:0] LAST_BNK = BITRBNK'(NUMRBNK - 1);
    localparam logic [BITRROW-1:0] LAST_ROW = BITRROW'(NUMRROW - 1);
    localparam logic [8:0]         FREQ     = 9'(REFFREQ);
    localparam logic               HALF     = (REFFRHF != 0);
    localparam logic [8:0]         MAXD     = 9'(MAXDEFER);

    state_t             state_r, state_nxt_s;
    logic [8:0]         cnt_r, period_s, age_inc_s;
    logic               phase_r;
    logic [1:0]         pend_r;
    logic [7:0]         age_r;
    logic [BITRBNK-1:0] rbnk_r;
    logic [BITRROW-1:0] rrow_r;
    logic               ovf_r;
    logic               tick_s, rd_conf_s, wr_conf_s, issue_s, defer_s, force_s, wrap_s;

    // Period selection, tick detection and same-bank conflict detection.
    always_comb begin
        period_s  = FREQ + {8'd0, HALF & phase_r};
        tick_s    = bus.ref_en && (cnt_r == (period_s - 9'd1));
        rd_conf_s = bus.rd_req && (bus.rd_rbnk == rbnk_r);
        wr_conf_s = bus.wr_req && (bus.wr_rbnk == rbnk_r);
        age_inc_s = {1'b0, age_r} + 9'd1;
    end

    // Scheduler next-state and issue/defer/force decisions.
    always_comb begin
        state_nxt_s = state_r;
        issue_s     = 1'b0;
        defer_s     = 1'b0;
        force_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.ref_en) state_nxt_s = RUN;
                else            state_nxt_s = IDLE;
            end
            RUN: begin
                if (!bus.ref_en) begin
                    state_nxt_s = IDLE;
                end else if (pend_r != 2'd0) begin
                    if (!(rd_conf_s || wr_conf_s)) begin
                        issue_s     = 1'b1;
                        state_nxt_s = RUN;
                    end else begin
                        defer_s = 1'b1;
                        // Age about to hit the bound: the next pending cycle wins unconditionally.
                        if (age_inc_s >= MAXD) state_nxt_s = FORCE;
                        else                   state_nxt_s = RUN;
                    end
                end else begin
                    state_nxt_s = RUN;
                end
            end
            FORCE: begin
                if (!bus.ref_en) begin
                    state_nxt_s = IDLE;
                end else begin
                    force_s     = 1'b1;
                    issue_s     = (pend_r != 2'd0);
                    state_nxt_s = RUN;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
        wrap_s = issue_s && (rbnk_r == LAST_BNK) && (rrow_r == LAST_ROW);
    end

    assign bus.rd_gnt   = bus.rd_req && !(force_s && rd_conf_s);
    assign bus.wr_gnt   = bus.wr_req && !(force_s && wr_conf_s);
    assign bus.ref_vld  = issue_s;
    assign bus.ref_wrap = wrap_s;
    assign bus.ref_rbnk = rbnk_r;
    assign bus.ref_rrow = rrow_r;
    assign bus.ref_ovf  = ovf_r;

    // Scheduler state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_r <= IDLE;
        else     state_r <= state_nxt_s;
    end

    // Refresh period counter; phase alternates the half-cycle period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r   <= 9'd0;
            phase_r <= 1'b0;
        end else if (!bus.ref_en) begin
            cnt_r   <= 9'd0;
        end else if (tick_s) begin
            cnt_r   <= 9'd0;
            phase_r <= ~phase_r;
        end else begin
            cnt_r   <= cnt_r + 9'd1;
        end
    end

    // Pending refresh count, saturating at 2, with sticky overflow on a lost tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_r <= 2'd0;
            ovf_r  <= 1'b0;
        end else begin
            case ({tick_s, issue_s})
                2'b10: begin
                    if (pend_r == 2'd2) ovf_r  <= 1'b1;
                    else                pend_r <= pend_r + 2'd1;
                end
                2'b01:   pend_r <= pend_r - 2'd1;
                default: pend_r <= pend_r;
            endcase
        end
    end

    // Deferral age of the oldest pending refresh.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                         age_r <= 8'd0;
        else if (!bus.ref_en || issue_s) age_r <= 8'd0;
        else if (defer_s)                age_r <= age_inc_s[7:0];
        else                             age_r <= age_r;
    end

    // Refresh address walk: bank fastest, row advances on bank wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rbnk_r <= '0;
            rrow_r <= '0;
        end else if (issue_s) begin
            if (rbnk_r == LAST_BNK) begin
                rbnk_r <= '0;
                rrow_r <= (rrow_r == LAST_ROW) ? '0 : rrow_r + BITRROW'(1);
            end else begin
                rbnk_r <= rbnk_r + BITRBNK'(1);
            end
        end else begin
            rbnk_r <= rbnk_r;
        end
    end

`ifdef REFSCHED_STATS_EN
    logic [15:0] blk_cnt_r;
    logic [1:0]  blk_inc_s;
    logic [16:0] blk_sum_s;

    // Number of grants suppressed this cycle by a forced refresh.
    always_comb begin
        blk_inc_s = {1'b0, force_s && rd_conf_s} + {1'b0, force_s && wr_conf_s};
        blk_sum_s = {1'b0, blk_cnt_r} + {15'd0, blk_inc_s};
    end

    // Saturating blocked-grant counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                blk_cnt_r <= 16'd0;
        else if (blk_sum_s[16]) blk_cnt_r <= 16'hFFFF;
        else                    blk_cnt_r <= blk_sum_s[15:0];
    end

    assign bus.blk_cnt = blk_cnt_r;
`endif
endmodule

// File: tb/tb_algo_1r1w_refresh_sched.sv
// Scoreboard bench: two scheduler configurations driven with random requests against a reference model.
module tb_algo_1r1w_refresh_sched;
    localparam int F0 = 6, H0 = 0, M0 = 3, NB0 = 2, BB0 = 1, NR0 = 256, BR0 = 8;
    localparam int F1 = 5, H1 = 1, M1 = 6, NB1 = 3, BB1 = 2, NR1 = 5,   BR1 = 3;

    typedef struct { int f, h, m, nb, nr; } cfg_t;
    typedef struct { int en_prev, cnt, phase, pend, age, bnk, row, ovf; } mst_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    algo_1r1w_refresh_sched_if #(.BITRBNK(BB0), .BITRROW(BR0)) if0 ();
    algo_1r1w_refresh_sched_if #(.BITRBNK(BB1), .BITRROW(BR1)) if1 ();

    algo_1r1w_refresh_sched #(.NUMRBNK(NB0), .BITRBNK(BB0), .NUMRROW(NR0), .BITRROW(BR0),
        .REFFREQ(F0), .REFFRHF(H0), .MAXDEFER(M0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    algo_1r1w_refresh_sched #(.NUMRBNK(NB1), .BITRBNK(BB1), .NUMRROW(NR1), .BITRROW(BR1),
        .REFFREQ(F1), .REFFRHF(H1), .MAXDEFER(M1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

    cfg_t c0, c1;
    mst_t m0, m1;
    int   q0[$], q1[$], v0[$], v1[$];
    int   n_cmp = 0, n_fail = 0, cyc = 0, en_cyc = 0;
    int   rec = 0, wseen0 = 0, wexp0 = 0;
    int   e0, e1, a0, a1;

    function automatic int pack(input logic ovf, wrap, vld, rg, wg, input int bnk, row);
        return (int'(ovf) << 15) | (int'(wrap) << 14) | (int'(vld) << 13) |
               (int'(rg) << 12) | (int'(wg) << 11) | (bnk << 8) | row;
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
        end
    endtask

    // Spec-level reference: one clock of scheduler behaviour in plain integer arithmetic.
    task automatic model_step(input cfg_t c, input mst_t m, input int en, rd, rb, wr, wb,
                              output mst_t n, output int word);
        int running, rc, wc, frc, issue, defer, wrap, per, tick, rdg, wrg;
        n       = m;
        running = (m.en_prev != 0) && (en != 0);
        rc      = (rd != 0) && (rb == m.bnk);
        wc      = (wr != 0) && (wb == m.bnk);
        frc     = running && m.pend > 0 && m.age >= c.m;
        issue   = running && m.pend > 0 && (frc || !(rc || wc));
        defer   = running && m.pend > 0 && !issue;
        rdg     = (rd != 0) && !(frc && rc);
        wrg     = (wr != 0) && !(frc && wc);
        wrap    = issue && m.bnk == c.nb - 1 && m.row == c.nr - 1;
        word    = pack(m.ovf[0], wrap[0], issue[0], rdg[0], wrg[0], m.bnk, m.row);
        per     = c.f + ((c.h != 0) ? m.phase : 0);
        tick    = (en != 0) && m.cnt == per - 1;
        n.cnt   = (en == 0 || tick) ? 0 : m.cnt + 1;
        if (tick) n.phase = 1 - m.phase;
        if (tick && !issue) begin
            if (m.pend == 2) n.ovf = 1;
            else             n.pend = m.pend + 1;
        end else if (issue && !tick) begin
            n.pend = m.pend - 1;
        end
        if (en == 0 || issue) n.age = 0;
        else if (defer)       n.age = m.age + 1;
        if (issue) begin
            if (m.bnk == c.nb - 1) begin
                n.bnk = 0;
                n.row = (m.row + 1) % c.nr;
            end else begin
                n.bnk = m.bnk + 1;
            end
        end
        n.en_prev = en;
    endtask

    // Drive one cycle of stimulus, push expected responses, advance the models.
    task automatic step(input int en, input int rdp, input int wrp, input int hold);
        int   rd0, rb0, wr0, wb0, rd1, rb1, wr1, wb1, w;
        mst_t n;
        rd0 = (hold != 0) ? 1 : int'($urandom_range(99) < rdp);
        rb0 = (hold != 0) ? m0.bnk : int'($urandom_range(NB0 - 1));
        wr0 = int'($urandom_range(99) < wrp);
        wb0 = int'($urandom_range(NB0 - 1));
        rd1 = (hold != 0) ? 1 : int'($urandom_range(99) < rdp);
        rb1 = (hold != 0) ? m1.bnk : int'($urandom_range(NB1 - 1));
        wr1 = int'($urandom_range(99) < wrp);
        wb1 = int'($urandom_range(NB1 - 1));
        if0.ref_en = en[0]; if0.rd_req = rd0[0]; if0.rd_rbnk = rb0[BB0-1:0];
        if0.wr_req = wr0[0]; if0.wr_rbnk = wb0[BB0-1:0];
        if1.ref_en = en[0]; if1.rd_req = rd1[0]; if1.rd_rbnk = rb1[BB1-1:0];
        if1.wr_req = wr1[0]; if1.wr_rbnk = wb1[BB1-1:0];
        if (rst) begin
            m0 = '{default: 0};
            m1 = '{default: 0};
        end
        model_step(c0, m0, en, rd0, rb0, wr0, wb0, n, w);
        q0.push_back(w);
        if (w[14]) wexp0++;
        m0 = rst ? '{default: 0} : n;
        model_step(c1, m1, en, rd1, rb1, wr1, wb1, n, w);
        q1.push_back(w);
        m1 = rst ? '{default: 0} : n;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Monitor: compare each presented cycle against the oldest queued expectation.
    always @(negedge clk) begin
        if (q0.size() > 0) begin
            e0 = q0.pop_front();
            a0 = pack(if0.ref_ovf, if0.ref_wrap, if0.ref_vld, if0.rd_gnt, if0.wr_gnt,
                      int'(if0.ref_rbnk), int'(if0.ref_rrow));
            chk("dut0_cycle", a0, e0);
            if (rec != 0 && if0.ref_vld) v0.push_back(cyc);
            if (if0.ref_wrap) wseen0++;
        end
        if (q1.size() > 0) begin
            e1 = q1.pop_front();
            a1 = pack(if1.ref_ovf, if1.ref_wrap, if1.ref_vld, if1.rd_gnt, if1.wr_gnt,
                      int'(if1.ref_rbnk), int'(if1.ref_rrow));
            chk("dut1_cycle", a1, e1);
            if (rec != 0 && if1.ref_vld) v1.push_back(cyc);
        end
    end

    initial begin
        c0 = '{F0, H0, M0, NB0, NR0};
        c1 = '{F1, H1, M1, NB1, NR1};
        m0 = '{default: 0};
        m1 = '{default: 0};
        rst = 1'b1;
        if0.ref_en = 1'b0; if0.rd_req = 1'b0; if0.rd_rbnk = '0; if0.wr_req = 1'b0; if0.wr_rbnk = '0;
        if1.ref_en = 1'b0; if1.rd_req = 1'b0; if1.rd_rbnk = '0; if1.wr_req = 1'b0; if1.wr_rbnk = '0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
        chk("reset_vld0", int'(if0.ref_vld), 0);
        chk("reset_addr0", int'({if0.ref_rbnk, if0.ref_rrow}), 0);
        chk("reset_ovf0", int'(if0.ref_ovf), 0);
        rst = 1'b0;
        for (int i = 0; i < 2; i++) step(0, 0, 0, 0);

        // Idle bus: refresh cadence after enable.
        rec = 1;
        en_cyc = cyc;
        for (int i = 0; i < 40; i++) step(1, 0, 0, 0);
        rec = 0;
        chk("nref0", v0.size(), 6);
        chk("first_ref0", (v0.size() > 0) ? v0[0] - en_cyc : -1, 6);
        for (int i = 0; i + 1 < v0.size(); i++) chk("interval0", v0[i+1] - v0[i], 6);
        chk("first_ref1", (v1.size() > 0) ? v1[0] - en_cyc : -1, 5);
        for (int i = 0; i + 1 < v1.size(); i++)
            chk("interval1", v1[i+1] - v1[i], (i % 2 == 0) ? 6 : 5);

        // Random traffic with occasional enable drops.
        for (int i = 0; i < 600; i++) step(int'($urandom_range(19) != 0), 50, 50, 0);

        // Persistent read conflict on the refresh bank: forcing and pend saturation.
        for (int i = 0; i < 80; i++) step(1, 0, 50, 1);
        chk("ovf_sticky1", int'(if1.ref_ovf), m1.ovf);

        // Asynchronous reset mid-deferral clears everything immediately.
        rst = 1'b1;
        m0 = '{default: 0};
        m1 = '{default: 0};
        #1;
        chk("async_rst_vld1", int'(if1.ref_vld), 0);
        chk("async_rst_ovf1", int'(if1.ref_ovf), 0);
        chk("async_rst_addr1", int'({if1.ref_rbnk, if1.ref_rrow}), 0);
        chk("async_rst_vld0", int'(if0.ref_vld), 0);
        for (int i = 0; i < 2; i++) step(0, 0, 0, 0);
        rst = 1'b0;

        // Full sweep of the refresh address space on the default configuration.
        wseen0 = 0;
        wexp0 = 0;
        for (int i = 0; i < 3150; i++) step(1, 0, 0, 0);
        chk("wrap_count0", wseen0, 1);
        chk("wrap_model0", wseen0, wexp0);

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
